logica_estado_vias: RTL

LOGICA_ESTADO_VIAS -- requirements
Module: logica_estado_vias

---
 rtl/logica_estado_vias_pkg.sv | 30 +++
 rtl/logica_estado_vias_lru_edad_set.sv | 140 ++++++++++++++
 rtl/logica_estado_vias.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/logica_estado_vias_pkg.sv
// ---------------------------------------------------------------------------
// logica_estado_vias_pkg
// Shared definitions for the cache way-state block:
//   - request operation encodings (READ / WRITE / FILL / INVAL)
//   - flush state-machine state type and state constants
//   - helper to recognise ordinary accesses (READ/WRITE)
// Imported by logica_estado_vias and lru_edad_set.
// ---------------------------------------------------------------------------
package logica_estado_vias_pkg;

  // Request operation codes carried on req_op
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_INVAL = 2'b11;

  // Flush state machine encoding (kept as plain constants so older tools
  // that dislike enums in ports/arrays can still consume it)
  typedef logic [1:0] flush_state_t;
  localparam flush_state_t FS_IDLE    = 2'd0;
  localparam flush_state_t FS_SCAN    = 2'd1;
  localparam flush_state_t FS_WB_WAIT = 2'd2;
  localparam flush_state_t FS_DONE    = 2'd3;

  // READ and WRITE need a valid line; FILL and INVAL do not
  function automatic logic is_access(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/logica_estado_vias_lru_edad_set.sv
// ---------------------------------------------------------------------------
// lru_edad_set
// State and replacement logic for one cache set: per-way invalid bit, dirty
// bit and age counter (age 0 = most recently used).
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_en_i          an accepted request targets this set this cycle
//   req_op_i          operation code (see package)
//   req_way_i         target way of the request
//   clr_en_i          clear the dirty bit of clr_way_i (flush write-back)
//   clr_way_i         way whose dirty bit is cleared
//   inv_o / dirty_o   per-way invalid and dirty bits (registered)
//   victim_way_o      lowest invalid way, otherwise the oldest way
//   victim_dirty_o    dirty bit of the victim line
//   victim_invalid_o  invalid bit of the victim line
// ---------------------------------------------------------------------------
module lru_edad_set
  import logica_estado_vias_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  localparam int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_en_i,
  input  logic [1:0]          req_op_i,
  input  logic [WAY_W-1:0]    req_way_i,
  input  logic                clr_en_i,
  input  logic [WAY_W-1:0]    clr_way_i,
  output logic [NUM_WAYS-1:0] inv_o,
  output logic [NUM_WAYS-1:0] dirty_o,
  output logic [WAY_W-1:0]    victim_way_o,
  output logic                victim_dirty_o,
  output logic                victim_invalid_o
);

  logic [NUM_WAYS-1:0] inv_q, inv_d;
  logic [NUM_WAYS-1:0] dirty_q, dirty_d;
  logic [WAY_W-1:0]    age_q     [NUM_WAYS];
  logic [WAY_W-1:0]    age_d     [NUM_WAYS];
  logic [WAY_W-1:0]    age_touch [NUM_WAYS];
  logic [WAY_W-1:0]    old_age;
  logic                touch;

  assign old_age = age_q[req_way_i];

  // Touch: the target becomes youngest; only ways younger than its old age
  // get one step older, so the ages stay a permutation of 0..NUM_WAYS-1.
  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_touch
      assign age_touch[gi] = (WAY_W'(gi) == req_way_i) ? '0 :
                             (age_q[gi] < old_age)     ? age_q[gi] + WAY_W'(1) :
                                                         age_q[gi];
    end
  endgenerate

  always_comb begin
    inv_d   = inv_q;
    dirty_d = dirty_q;
    age_d   = age_q;
    touch   = 1'b0;
    if (req_en_i) begin
      case (req_op_i)
        OP_READ: begin
          touch = ~inv_q[req_way_i];
        end
        OP_WRITE: begin
          // A write to an invalid line is an error and must leave no trace
          if (!inv_q[req_way_i]) begin
            touch              = 1'b1;
            dirty_d[req_way_i] = 1'b1;
          end
        end
        OP_FILL: begin
          inv_d[req_way_i]   = 1'b0;
          dirty_d[req_way_i] = 1'b0;
          touch              = 1'b1;
        end
        OP_INVAL: begin
          inv_d[req_way_i]   = 1'b1;
          dirty_d[req_way_i] = 1'b0;
        end
        default: ;
      endcase
    end
    if (clr_en_i) begin
      dirty_d[clr_way_i] = 1'b0;
    end
    if (touch) begin
      age_d = age_touch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q   <= '1;
      dirty_q <= '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        age_q[w] <= WAY_W'(w);
      end
    end else begin
      inv_q   <= inv_d;
      dirty_q <= dirty_d;
      age_q   <= age_d;
    end
  end

  // Victim selection works on registered state only, so a same-cycle
  // request never influences the answer.
  logic             found_inv;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] old_way;
  logic [WAY_W-1:0] max_age;

  always_comb begin
    found_inv = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found_inv && inv_q[w]) begin
        found_inv = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    old_way = '0;
    max_age = age_q[0];
    for (int w = 1; w < NUM_WAYS; w++) begin
      if (age_q[w] > max_age) begin
        old_way = WAY_W'(w);
        max_age = age_q[w];
      end
    end
  end

  assign victim_way_o     = found_inv ? inv_way : old_way;
  assign victim_dirty_o   = dirty_q[victim_way_o];
  assign victim_invalid_o = inv_q[victim_way_o];
  assign inv_o            = inv_q;
  assign dirty_o          = dirty_q;

endmodule

// File: rtl/logica_estado_vias.sv
// ---------------------------------------------------------------------------
// logica_estado_vias
// Way-state tracker for a set-associative cache: invalid/dirty bits and
// age-based LRU per line, victim query, and an optional flush engine that
// writes back every valid dirty line.
// Optional feature macro: LOGICA_ESTADO_VIAS_FLUSH_EN builds the flush FSM;
// without it flush_start is ignored and flush_busy/flush_done/wb_valid are 0.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (ready while not flushing)
//   req_op, req_set, req_way     operation and target line
//   req_err                      pulse after an access to an invalid line
//   query_set                    set whose victim is reported
//   victim_way/dirty/invalid     combinational victim of query_set
//   flush_start/busy/done        flush control and status
//   wb_valid/wb_ready            write-back handshake during flush
//   wb_set, wb_way               line being written back
// ---------------------------------------------------------------------------
module logica_estado_vias
  import logica_estado_vias_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2,
  localparam int SET_W = $clog2(NUM_SETS),
  localparam int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [SET_W-1:0] req_set,
  input  logic [WAY_W-1:0] req_way,
  output logic             req_err,
  input  logic [SET_W-1:0] query_set,
  output logic [WAY_W-1:0] victim_way,
  output logic             victim_dirty,
  output logic             victim_invalid,
  input  logic             flush_start,
  output logic             flush_busy,
  output logic             flush_done,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [SET_W-1:0] wb_set,
  output logic [WAY_W-1:0] wb_way
);

  logic                req_accept;
  logic                wb_clr_en;
  logic                err_q, err_d;
  logic [NUM_WAYS-1:0] inv_vec   [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_vec [NUM_SETS];
  logic [WAY_W-1:0]    vic_way   [NUM_SETS];
  logic [NUM_SETS-1:0] vic_dirty;
  logic [NUM_SETS-1:0] vic_inv;

  assign req_ready  = ~flush_busy;
  assign req_accept = req_valid & req_ready;

  generate
    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
      lru_edad_set #(
        .NUM_WAYS (NUM_WAYS)
      ) u_set (
        .clk              (clk),
        .rst              (rst),
        .req_en_i         (req_accept && (req_set == SET_W'(gi))),
        .req_op_i         (req_op),
        .req_way_i        (req_way),
        .clr_en_i         (wb_clr_en && (wb_set == SET_W'(gi))),
        .clr_way_i        (wb_way),
        .inv_o            (inv_vec[gi]),
        .dirty_o          (dirty_vec[gi]),
        .victim_way_o     (vic_way[gi]),
        .victim_dirty_o   (vic_dirty[gi]),
        .victim_invalid_o (vic_inv[gi])
      );
    end
  endgenerate

  assign victim_way     = vic_way[query_set];
  assign victim_dirty   = vic_dirty[query_set];
  assign victim_invalid = vic_inv[query_set];

  // Error is judged against the pre-update line state
  assign err_d = req_accept && is_access(req_op) && inv_vec[req_set][req_way];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign req_err = err_q;

`ifdef LOGICA_ESTADO_VIAS_FLUSH_EN
  localparam int LINE_W = SET_W + WAY_W;

  flush_state_t      state_q, state_d;
  logic [LINE_W-1:0] idx_q, idx_d;
  logic [SET_W-1:0]  scan_set;
  logic [WAY_W-1:0]  scan_way;
  logic              scan_hit;
  logic              last_line;

  // Line index is set-major, way-minor: upper bits set, lower bits way
  assign scan_set  = idx_q[LINE_W-1:WAY_W];
  assign scan_way  = idx_q[WAY_W-1:0];
  assign scan_hit  = dirty_vec[scan_set][scan_way] & ~inv_vec[scan_set][scan_way];
  assign last_line = &idx_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wb_clr_en = 1'b0;
    case (state_q)
      FS_IDLE: begin
        if (flush_start) begin
          state_d = FS_SCAN;
          idx_d   = '0;
        end
      end
      FS_SCAN: begin
        if (scan_hit) begin
          state_d = FS_WB_WAIT;
        end else if (last_line) begin
          state_d = FS_DONE;
        end else begin
          idx_d = idx_q + LINE_W'(1);
        end
      end
      FS_WB_WAIT: begin
        // idx_q is frozen here, which keeps wb_set/wb_way stable
        if (wb_ready) begin
          wb_clr_en = 1'b1;
          if (last_line) begin
            state_d = FS_DONE;
          end else begin
            state_d = FS_SCAN;
            idx_d   = idx_q + LINE_W'(1);
          end
        end
      end
      FS_DONE: begin
        state_d = FS_IDLE;
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign flush_busy = (state_q != FS_IDLE);
  assign flush_done = (state_q == FS_DONE);
  assign wb_valid   = (state_q == FS_WB_WAIT);
  assign wb_set     = scan_set;
  assign wb_way     = scan_way;
`else
  // Flush engine absent: inputs are sunk, outputs held inactive
  logic                unused_flush_in;
  logic [NUM_SETS-1:0] unused_dirty;

  assign unused_flush_in = &{1'b0, flush_start, wb_ready};
  generate
    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_unused
      assign unused_dirty[gi] = |dirty_vec[gi];
    end
  endgenerate

  assign wb_clr_en  = 1'b0;
  assign flush_busy = 1'b0;
  assign flush_done = 1'b0;
  assign wb_valid   = 1'b0;
  assign wb_set     = '0;
  assign wb_way     = '0;
`endif

endmodule
